display_mux: RTL and testbench
==============================

// Module: display_mux
// PURPOSE
//   Time-multiplexes two hex digits onto one shared active-low seven-segment bus.
//   Sits directly downstream of the clock divider and consumes its divided square
//   wave clk_signal: every toggle of clk_signal hands the display to the other digit.
//   Inserts a blanking interval with both anodes off at every handover to prevent
//   ghosting. Drives the two PNP anode transistors and the segment pins of the board.
// PARAMETERS
//   BLANK_CYCLES  16  clk cycles with both anodes off per handover; legal range >= 1
//   CW            $clog2(BLANK_CYCLES+1)  blank counter width (derived, do not override)
// PORTS
//   clk         input   1  system clock (24 MHz on board)
//   reset       input   1  asynchronous, active-low reset
//   clk_signal  input   1  divided square wave from the clock divider, synchronous to clk
//   s0          input   4  hex value shown on digit 0
//   s1          input   4  hex value shown on digit 1
//   seg         output  7  segment drive, active-low, bit order {g,f,e,d,c,b,a}
//   anode       output  2  digit enables, active-low; anode[0] = digit 0, anode[1] = digit 1
//   digit_sel   output  1  digit currently lit, or the next to be lit while blanking
// BEHAVIOUR
//   - All outputs are registered. No combinational path from any input to any output.
//   - Reset (reset == 0, asynchronous):
//     state = BLANK_TO0, blank counter = 0, tick_q = 0,
//     seg = 7'h7F, anode = 2'b11, digit_sel = 0.
//   - Edge detect: tick_q <= clk_signal every clk. edge = clk_signal ^ tick_q.
//     Both rising and falling edges of clk_signal count.
//   - FSM states: BLANK_TO0, SHOW0, BLANK_TO1, SHOW1.
//   - BLANK_TOx:
//     * seg = 7'h7F, anode = 2'b11, digit_sel = x.
//     * Counter increments every clk.
//     * On the clk where counter == BLANK_CYCLES-1: counter <= 0, state <= SHOWx,
//       anode[x] <= 0, seg <= decode(sx).
//     * The blank interval is therefore exactly BLANK_CYCLES clks.
//     * Edges arriving during BLANK are dropped. They do not shorten, extend, or
//       queue the blank interval.
//   - SHOWx:
//     * seg <= decode(sx) every clk, so a change on sx appears 1 clk later.
//     * anode has only bit x low.
//     * On any clk with edge == 1: state <= BLANK_TO(1-x), seg <= 7'h7F,
//       anode <= 2'b11, digit_sel <= 1-x.
//       The anode turns off on that same clk edge.
//   - After reset release, the first SHOW0 begins at the BLANK_CYCLES-th rising clk
//     edge. Every clk_signal edge during SHOW then alternates the digits.
//   - Decode (hex -> seg), values in hex:
//     0:40  1:79  2:24  3:30  4:19  5:12  6:02  7:78
//     8:00  9:10  A:08  b:03  C:46  d:21  E:06  F:0E
//   - anode == 2'b00 is illegal and must never occur. Only one digit may be lit.
//   - Reset asserted mid-SHOW or mid-BLANK forces the reset values immediately,
//     without waiting for clk.
// TESTING
//   - Reset: hold reset=0 with s0=3, s1=8 -> seg=7F, anode=11, digit_sel=0 throughout.
//   - Startup: BLANK_CYCLES=4, release reset, clk_signal held at 0 -> anode=11 for
//     3 clks, then anode=10 and seg=30 from the 4th clk onward.
//   - Handover: in SHOW0, toggle clk_signal 0->1 with s1=A
//     -> next clk: anode=11, digit_sel=1; 4 clks later: anode=01, seg=08.
//   - Live update: in SHOW1, change s1 from A to F -> seg becomes 0E one clk later;
//     anode stays 01.
//   - Blank masking: toggle clk_signal twice during BLANK_TO1 -> blank still lasts
//     exactly 4 clks and SHOW1 is entered; no extra handover occurs.
//   - Full-rate run: drive clk_signal from the real divider (toggle every 2000 clks)
//     for 20 toggles -> digits alternate on every toggle; a checker flags any
//     anode==00; every segment pattern 0..F is checked against the decode table.

Source files
------------

// File: rtl/display_mux.sv
// display_mux
//   Time-multiplexes two hex digits onto one shared active-low seven-segment
//   bus. Every edge (rising or falling) of the divided square wave clk_signal
//   hands the display to the other digit, with a fixed blanking interval
//   (both anodes off) at every handover so the old segment pattern never
//   ghosts onto the newly enabled digit.
// Ports
//   clk        : system clock
//   reset      : asynchronous, active-low reset
//   clk_signal : divided square wave, synchronous to clk
//   s0, s1     : hex values for digit 0 and digit 1
//   seg        : segment drive, active-low, {g,f,e,d,c,b,a}
//   anode      : digit enables, active-low; anode[0] = digit 0
//   digit_sel  : digit currently lit, or the next one while blanking
module display_mux #(
  parameter int BLANK_CYCLES = 16,
  localparam int CW = $clog2(BLANK_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_signal,
  input  logic [3:0] s0,
  input  logic [3:0] s1,
  output logic [6:0] seg,
  output logic [1:0] anode,
  output logic       digit_sel
);

  typedef enum logic [1:0] {
    BLANK_TO0 = 2'd0,
    SHOW0     = 2'd1,
    BLANK_TO1 = 2'd2,
    SHOW1     = 2'd3
  } state_t;

  localparam logic [6:0] SEG_OFF   = 7'h7F;
  localparam logic [1:0] ANODE_OFF = 2'b11;
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  // Hex to active-low segment pattern, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] p;
    case (v)
      4'h0: p = 7'h40;
      4'h1: p = 7'h79;
      4'h2: p = 7'h24;
      4'h3: p = 7'h30;
      4'h4: p = 7'h19;
      4'h5: p = 7'h12;
      4'h6: p = 7'h02;
      4'h7: p = 7'h78;
      4'h8: p = 7'h00;
      4'h9: p = 7'h10;
      4'hA: p = 7'h08;
      4'hB: p = 7'h03;
      4'hC: p = 7'h46;
      4'hD: p = 7'h21;
      4'hE: p = 7'h06;
      4'hF: p = 7'h0E;
      default: p = 7'h7F;
    endcase
    return p;
  endfunction

  state_t        state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic          tick_r;
  logic [6:0]    seg_r, seg_s;
  logic [1:0]    anode_r, anode_s;
  logic          digit_sel_r, digit_sel_s;
  logic          edge_s;

  // Either transition of clk_signal is a handover request.
  assign edge_s = clk_signal ^ tick_r;

  // Next-state and next-output logic; everything is registered below.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    seg_s       = seg_r;
    anode_s     = anode_r;
    digit_sel_s = digit_sel_r;
    case (state_r)
      BLANK_TO0: begin
        // Edges are ignored here: blank length is fixed.
        seg_s       = SEG_OFF;
        anode_s     = ANODE_OFF;
        digit_sel_s = 1'b0;
        if (cnt_r == BLANK_LAST) begin
          cnt_s   = '0;
          state_s = SHOW0;
          anode_s = 2'b10;
          seg_s   = decode(s0);
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      SHOW0: begin
        cnt_s       = '0;
        seg_s       = decode(s0);
        anode_s     = 2'b10;
        digit_sel_s = 1'b0;
        if (edge_s) begin
          state_s     = BLANK_TO1;
          seg_s       = SEG_OFF;
          anode_s     = ANODE_OFF;
          digit_sel_s = 1'b1;
        end else begin
          state_s = SHOW0;
        end
      end
      BLANK_TO1: begin
        seg_s       = SEG_OFF;
        anode_s     = ANODE_OFF;
        digit_sel_s = 1'b1;
        if (cnt_r == BLANK_LAST) begin
          cnt_s   = '0;
          state_s = SHOW1;
          anode_s = 2'b01;
          seg_s   = decode(s1);
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      SHOW1: begin
        cnt_s       = '0;
        seg_s       = decode(s1);
        anode_s     = 2'b01;
        digit_sel_s = 1'b1;
        if (edge_s) begin
          state_s     = BLANK_TO0;
          seg_s       = SEG_OFF;
          anode_s     = ANODE_OFF;
          digit_sel_s = 1'b0;
        end else begin
          state_s = SHOW1;
        end
      end
      default: begin
        // Unreachable encoding: fall back to a dark, safe restart.
        state_s     = BLANK_TO0;
        cnt_s       = '0;
        seg_s       = SEG_OFF;
        anode_s     = ANODE_OFF;
        digit_sel_s = 1'b0;
      end
    endcase
  end

  // State, counter, edge-detect and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= BLANK_TO0;
      cnt_r       <= '0;
      tick_r      <= 1'b0;
      seg_r       <= SEG_OFF;
      anode_r     <= ANODE_OFF;
      digit_sel_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      tick_r      <= clk_signal;
      seg_r       <= seg_s;
      anode_r     <= anode_s;
      digit_sel_r <= digit_sel_s;
    end
  end

  assign seg       = seg_r;
  assign anode     = anode_r;
  assign digit_sel = digit_sel_r;

endmodule

// File: tb/tb_display_mux.sv
module tb_display_mux;

  logic       clk;
  logic       reset;
  logic       clk_signal;
  logic [3:0] s0, s1;
  logic [6:0] seg;
  logic [1:0] anode;
  logic       digit_sel;

  int vectors;
  int miscompares;

  logic [6:0] exp_tab [16];

  display_mux #(.BLANK_CYCLES(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .clk_signal (clk_signal),
    .s0         (s0),
    .s1         (s1),
    .seg        (seg),
    .anode      (anode),
    .digit_sel  (digit_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Only one digit may ever be lit.
  always @(negedge clk) begin
    if (anode === 2'b00) begin
      miscompares++;
      $display("FAIL anode_both_on: anode=%b required never 00 at %0t", anode, $time);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; clk_signal = 1'b0; s0 = 4'h3; s1 = 4'h8;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (seg !== 7'h7F || anode !== 2'b11 || digit_sel !== 1'b0) begin
        miscompares++;
        $display("FAIL reset: seg=%h anode=%b sel=%b required 7f 11 0", seg, anode, digit_sel);
      end
    end
  endtask

  task automatic test_startup();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (anode !== 2'b11 || seg !== 7'h7F) begin
        miscompares++;
        $display("FAIL startup_blank[%0d]: anode=%b seg=%h required 11 7f", i, anode, seg);
      end
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if (anode !== 2'b10 || seg !== 7'h30 || digit_sel !== 1'b0) begin
        miscompares++;
        $display("FAIL startup_show0[%0d]: anode=%b seg=%h sel=%b required 10 30 0", i, anode, seg, digit_sel);
      end
    end
  endtask

  task automatic test_handover();
    s1 = 4'hA; clk_signal = 1'b1;
    tick();
    vectors++;
    if (anode !== 2'b11 || digit_sel !== 1'b1 || seg !== 7'h7F) begin
      miscompares++;
      $display("FAIL handover_off: anode=%b sel=%b seg=%h required 11 1 7f", anode, digit_sel, seg);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (anode !== 2'b11) begin
        miscompares++;
        $display("FAIL handover_blank[%0d]: anode=%b required 11", i, anode);
      end
    end
    tick();
    vectors++;
    if (anode !== 2'b01 || seg !== 7'h08 || digit_sel !== 1'b1) begin
      miscompares++;
      $display("FAIL handover_show1: anode=%b seg=%h sel=%b required 01 08 1", anode, seg, digit_sel);
    end
  endtask

  task automatic test_live_update();
    s1 = 4'hF;
    tick();
    vectors++;
    if (seg !== 7'h0E || anode !== 2'b01) begin
      miscompares++;
      $display("FAIL live_update: seg=%h anode=%b required 0e 01", seg, anode);
    end
  endtask

  task automatic test_blank_masking();
    // SHOW1 -> BLANK_TO0 -> SHOW0 first, so the masking happens in BLANK_TO1.
    s0 = 4'h5; s1 = 4'hC;
    clk_signal = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    vectors++;
    if (anode !== 2'b10 || seg !== 7'h12) begin
      miscompares++;
      $display("FAIL mask_show0: anode=%b seg=%h required 10 12", anode, seg);
    end
    clk_signal = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      clk_signal = (i < 2) ? ~clk_signal : clk_signal;
      tick();
      vectors++;
      if (anode !== 2'b11 || digit_sel !== 1'b1) begin
        miscompares++;
        $display("FAIL mask_blank[%0d]: anode=%b sel=%b required 11 1", i, anode, digit_sel);
      end
    end
    tick();
    vectors++;
    if (anode !== 2'b01 || seg !== 7'h46) begin
      miscompares++;
      $display("FAIL mask_show1: anode=%b seg=%h required 01 46", anode, seg);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (anode !== 2'b01 || digit_sel !== 1'b1) begin
        miscompares++;
        $display("FAIL mask_no_extra[%0d]: anode=%b sel=%b required 01 1", i, anode, digit_sel);
      end
    end
  endtask

  task automatic test_async_reset();
    // Currently in SHOW1; assert reset between clock edges.
    #2;
    reset = 1'b0;
    #1;
    vectors++;
    if (seg !== 7'h7F || anode !== 2'b11 || digit_sel !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: seg=%h anode=%b sel=%b required 7f 11 0", seg, anode, digit_sel);
    end
    clk_signal = 1'b0;
    tick();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    vectors++;
    if (anode !== 2'b10 || seg !== 7'h12) begin
      miscompares++;
      $display("FAIL reset_restart: anode=%b seg=%h required 10 12", anode, seg);
    end
  endtask

  task automatic test_full_rate();
    logic exp_sel;
    logic [3:0] v;
    exp_sel = 1'b0;
    for (int k = 0; k < 20; k++) begin
      v = 4'(k);
      s0 = v; s1 = v;
      clk_signal = ~clk_signal;
      exp_sel = ~exp_sel;
      tick();
      vectors++;
      if (anode !== 2'b11 || digit_sel !== exp_sel) begin
        miscompares++;
        $display("FAIL full_handover[%0d]: anode=%b sel=%b required 11 %b", k, anode, digit_sel, exp_sel);
      end
      for (int i = 1; i < 2000; i++) begin
        tick();
        if (i == 1000) begin
          vectors++;
          if (seg !== exp_tab[v] || anode !== (exp_sel ? 2'b01 : 2'b10) || digit_sel !== exp_sel) begin
            miscompares++;
            $display("FAIL full_show[%0d]: seg=%h anode=%b sel=%b required %h %b %b",
                     k, seg, anode, digit_sel, exp_tab[v], (exp_sel ? 2'b01 : 2'b10), exp_sel);
          end
        end
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    exp_tab[0]  = 7'h40; exp_tab[1]  = 7'h79; exp_tab[2]  = 7'h24; exp_tab[3]  = 7'h30;
    exp_tab[4]  = 7'h19; exp_tab[5]  = 7'h12; exp_tab[6]  = 7'h02; exp_tab[7]  = 7'h78;
    exp_tab[8]  = 7'h00; exp_tab[9]  = 7'h10; exp_tab[10] = 7'h08; exp_tab[11] = 7'h03;
    exp_tab[12] = 7'h46; exp_tab[13] = 7'h21; exp_tab[14] = 7'h06; exp_tab[15] = 7'h0E;
    test_reset();
    test_startup();
    test_handover();
    test_live_update();
    test_blank_masking();
    test_async_reset();
    test_full_rate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
